// File: rtl/tdm_demux_16.sv
// tdm_demux_16: 16-slot TDM serial demultiplexer with frame alignment and sync checking
module tdm_demux_16 #(
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        frame_sync,
    output logic [15:0] route,
    output logic        route_valid,
    output logic [15:0] frame,
    output logic        frame_valid,
    output logic [3:0]  slot,
    output logic        sync_err
);
    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [14:0] shadow_q, shadow_d;
    logic [15:0] route_q, route_d;
    logic        route_valid_q, route_valid_d;
    logic [15:0] frame_q, frame_d;
    logic        frame_valid_q, frame_valid_d;
    logic        sync_err_q, sync_err_d;
    logic        hunt, early, missing, accept, last;
    logic [3:0]  acc_slot;

    // Classify the sample and compute next state; an early sync restarts the frame at slot 0
    always_comb begin
        hunt          = state_q == HUNT;
        early         = !hunt && din_valid && frame_sync && slot_q != 4'd0;
        missing       = SYNC_CHECK && !hunt && din_valid && !frame_sync && slot_q == 4'd0;
        accept        = din_valid && (hunt ? frame_sync : !missing);
        acc_slot      = (hunt || early) ? 4'd0 : slot_q;
        last          = accept && acc_slot == 4'd15;
        shadow_d      = shadow_q;
        if (accept && !last)
            shadow_d[acc_slot] = din;
        route_d       = accept ? ({15'b0, din} << acc_slot) : 16'b0;
        route_valid_d = accept;
        frame_d       = last ? {din, shadow_q} : frame_q;
        frame_valid_d = last;
        sync_err_d    = early || missing;
        slot_d        = accept ? acc_slot + 4'd1 : slot_q;
        state_d       = missing ? HUNT : (accept ? RUN : state_q);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= 4'd0;
            shadow_q      <= 15'b0;
            route_q       <= 16'b0;
            route_valid_q <= 1'b0;
            frame_q       <= 16'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            route_q       <= route_d;
            route_valid_q <= route_valid_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign route       = route_q;
    assign route_valid = route_valid_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux_16.sv
// tb_tdm_demux_16: table, directed and random checks of tdm_demux_16 with and without sync checking
module tb_tdm_demux_16;
    logic clk = 1'b0;
    logic rst_n, din, din_valid, frame_sync;
    logic [15:0] route_a, frame_a, route_b, frame_b;
    logic        rv_a, fv_a, err_a, rv_b, fv_b, err_b;
    logic [3:0]  slot_a, slot_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: index 0 models SYNC_CHECK=1, index 1 models SYNC_CHECK=0
    logic        m_al[2];
    int          m_pos[2];
    logic [15:0] m_buf[2];
    logic [15:0] m_route[2];
    logic [15:0] m_frame[2];
    logic        m_rv[2], m_fv[2], m_err[2];

    typedef struct {
        logic        v, fs, d;
        logic        rv;
        logic [15:0] route;
        logic [3:0]  slot;
        logic        fv, err;
    } vec_t;
    vec_t vecs[17];

    always #5 clk = ~clk;

    tdm_demux_16 #(.SYNC_CHECK(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .route(route_a), .route_valid(rv_a), .frame(frame_a), .frame_valid(fv_a),
        .slot(slot_a), .sync_err(err_a)
    );

    tdm_demux_16 #(.SYNC_CHECK(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .route(route_b), .route_valid(rv_b), .frame(frame_b), .frame_valid(fv_b),
        .slot(slot_b), .sync_err(err_b)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_al[i] = 1'b0; m_pos[i] = 0; m_buf[i] = '0; m_route[i] = '0;
            m_frame[i] = '0; m_rv[i] = 1'b0; m_fv[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic v, input logic fs, input logic d);
        for (int i = 0; i < 2; i++) begin
            int   p;
            logic acc;
            m_rv[i] = 1'b0; m_route[i] = '0; m_fv[i] = 1'b0; m_err[i] = 1'b0;
            acc = 1'b0;
            p = m_pos[i];
            if (v) begin
                if (!m_al[i]) begin
                    if (fs) begin acc = 1'b1; p = 0; end
                end else if (fs && m_pos[i] != 0) begin
                    m_err[i] = 1'b1; acc = 1'b1; p = 0;
                end else if (!fs && m_pos[i] == 0 && i == 0) begin
                    m_err[i] = 1'b1; m_al[i] = 1'b0;
                end else begin
                    acc = 1'b1;
                end
            end
            if (acc) begin
                m_buf[i][p]   = d;
                m_rv[i]       = 1'b1;
                m_route[i][p] = d;
                m_al[i]       = 1'b1;
                m_pos[i]      = (p + 1) % 16;
                if (p == 15) begin
                    m_frame[i] = m_buf[i];
                    m_fv[i]    = 1'b1;
                end
            end
        end
    endtask

    task automatic check_dut();
        chk("route_a", route_a, m_route[0]);
        chk("rv_a", 16'(rv_a), 16'(m_rv[0]));
        chk("frame_a", frame_a, m_frame[0]);
        chk("fv_a", 16'(fv_a), 16'(m_fv[0]));
        chk("slot_a", 16'(slot_a), 16'(m_pos[0]));
        chk("err_a", 16'(err_a), 16'(m_err[0]));
        chk("route_b", route_b, m_route[1]);
        chk("rv_b", 16'(rv_b), 16'(m_rv[1]));
        chk("frame_b", frame_b, m_frame[1]);
        chk("fv_b", 16'(fv_b), 16'(m_fv[1]));
        chk("slot_b", 16'(slot_b), 16'(m_pos[1]));
        chk("err_b", 16'(err_b), 16'(m_err[1]));
    endtask

    task automatic drive(input logic v, input logic fs, input logic d);
        din_valid = v; frame_sync = fs; din = d;
        @(posedge clk);
        #1;
        model_step(v, fs, d);
        check_dut();
    endtask

    task automatic send_bits(input logic [15:0] f, input logic sync0, input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, i == 0 ? sync0 : 1'b0, f[i]);
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'hA5C3;
        for (int k = 0; k < 16; k++)
            vecs[k] = '{v: 1'b1, fs: k == 0, d: pat[k], rv: 1'b1,
                        route: pat[k] ? (16'd1 << k) : 16'd0,
                        slot: 4'((k + 1) % 16), fv: k == 15, err: 1'b0};
        vecs[16] = '{v: 1'b0, fs: 1'b0, d: 1'b0, rv: 1'b0, route: 16'd0, slot: 4'd0, fv: 1'b0, err: 1'b0};

        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_dut();
        rst_n = 1'b1;

        // Aligned frame A5C3 from a table of expected per-cycle outputs
        for (int k = 0; k < 17; k++) begin
            drive(vecs[k].v, vecs[k].fs, vecs[k].d);
            chk("tbl_rv", 16'(rv_a), 16'(vecs[k].rv));
            chk("tbl_route", route_a, vecs[k].route);
            chk("tbl_slot", 16'(slot_a), 16'(vecs[k].slot));
            chk("tbl_fv", 16'(fv_a), 16'(vecs[k].fv));
            chk("tbl_err", 16'(err_a), 16'(vecs[k].err));
        end
        chk("tbl_frame", frame_a, 16'hA5C3);

        // Unsynced bits while hunting: first put dut_a into HUNT via a missing sync
        drive(1'b1, 1'b0, 1'b1);
        chk("miss_err", 16'(err_a), 16'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            chk("hunt_rv", 16'(rv_a), 16'd0);
            chk("hunt_slot", 16'(slot_a), 16'd0);
        end
        send_bits(16'h0001, 1'b1, 16);
        drive(1'b0, 1'b0, 1'b0);
        chk("f0001_a", frame_a, 16'h0001);

        // Early sync at slot 7 aborts the partial frame
        send_bits(16'hFFFF, 1'b1, 7);
        drive(1'b1, 1'b1, 1'b0);
        chk("early_err", 16'(err_a), 16'd1);
        chk("early_slot", 16'(slot_a), 16'd1);
        send_bits(16'h7E00, 1'b0, 15);
        chk("resync_fv", 16'(fv_a), 16'd1);
        chk("resync_frame", frame_a, 16'hFC00);

        // Back-to-back frames with the second sync omitted
        send_bits(16'h5A5A, 1'b1, 16);
        send_bits(16'h3C3C, 1'b0, 16);
        drive(1'b0, 1'b0, 1'b0);
        chk("b2b_a", frame_a, 16'h5A5A);
        chk("b2b_b", frame_b, 16'h3C3C);

        // Valid gaps inside an all-ones frame
        for (int i = 0; i < 16; i++) begin
            int g;
            g = $urandom_range(0, 3);
            for (int j = 0; j < g; j++) drive(1'b0, 1'b0, 1'b0);
            drive(1'b1, i == 0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_frame", frame_a, 16'hFFFF);

        // Asynchronous reset between edges at slot 9
        send_bits(16'h00FF, 1'b1, 9);
        chk("pre_rst_slot", 16'(slot_a), 16'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_route", route_a, 16'd0);
        chk("rst_rv", 16'(rv_a), 16'd0);
        chk("rst_frame", frame_a, 16'd0);
        chk("rst_slot", 16'(slot_a), 16'd0);
        chk("rst_frame_b", frame_b, 16'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        send_bits(16'h1234, 1'b1, 16);
        drive(1'b0, 1'b0, 1'b0);
        chk("f1234", frame_a, 16'h1234);

        // Randomized stream, mostly aligned with occasional sync faults
        for (int n = 0; n < 3000; n++) begin
            logic v, fs;
            v  = $urandom_range(0, 3) != 0;
            fs = (m_pos[0] == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 30) == 0);
            drive(v, fs, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
